// File: rtl/qspi_flash_resp.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_flash_resp
//  Description : QSPI flash responder model. Answers the Quad I/O Fast Read
//                command (0xEB) from a preloadable byte array, including the
//                continuous-read (command-less) mode armed by the mode byte.
//                All QSPI pins are oversampled by clk, which must run at
//                least 4x faster than SCK.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_flash_resp #(
  parameter int ADDR_BITS    = 10,
  parameter int DUMMY_CYCLES = 4   // must be >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 ce_n,
  input  logic [3:0]           din,
  output logic [3:0]           dout,
  output logic                 douten,
  input  logic                 mem_we,
  input  logic [ADDR_BITS-1:0] mem_waddr,
  input  logic [7:0]           mem_wdata,
  output logic                 cont_mode,
  output logic                 bad_cmd
);

  localparam logic [7:0] c_CMD_QIOR  = 8'hEB;
  localparam logic [7:0] c_LAST_DUMMY = 8'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_MODE   = 3'd3,
    S_DUMMY  = 3'd4,
    S_DATA   = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  // Pin sampling registers and their one-cycle-delayed copies for edge detect
  logic       sck_q, sck_prev_q;
  logic       ce_n_q, ce_n_prev_q;
  logic [3:0] din_q;

  // Protocol state
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0] mode_hi_q, mode_hi_d;   // mode[5:4], captured from the first mode nibble
  logic       nib_lo_q, nib_lo_d;     // next nibble to present is the low one
  logic       cont_q, cont_d;
  logic       bad_q, bad_d;
  logic [3:0] dout_q, dout_d;

  // Byte array (intentionally not reset)
  logic [7:0] mem_q [0:(1<<ADDR_BITS)-1];

  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_ce_fall;
  logic [7:0] w_rd_byte;
  logic [7:0] w_cmd_full;

  // Synchronise the QSPI pins. ce_n resets to the "selected" level so that a
  // ce_n already low when rst is released does not look like a new falling
  // edge; only a genuine high-to-low transition starts a transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q       <= 1'b0;
      sck_prev_q  <= 1'b0;
      ce_n_q      <= 1'b0;
      ce_n_prev_q <= 1'b0;
      din_q       <= 4'h0;
    end else begin
      sck_q       <= sck;
      sck_prev_q  <= sck_q;
      ce_n_q      <= ce_n;
      ce_n_prev_q <= ce_n_q;
      din_q       <= din;
    end
  end

  // SCK edges only count while the chip is selected
  assign w_sck_rise = sck_q & ~sck_prev_q & ~ce_n_q;
  assign w_sck_fall = ~sck_q & sck_prev_q & ~ce_n_q;
  assign w_ce_fall  = ~ce_n_q & ce_n_prev_q;
  assign w_rd_byte  = mem_q[addr_q[ADDR_BITS-1:0]];
  assign w_cmd_full = {cmd_q, din_q[0]};

  // Preload port; a read of the same byte in this cycle sees the old value
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      cmd_q     <= 7'd0;
      addr_q    <= 24'd0;
      mode_hi_q <= 2'b00;
      nib_lo_q  <= 1'b0;
      cont_q    <= 1'b0;
      bad_q     <= 1'b0;
      dout_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      mode_hi_q <= mode_hi_d;
      nib_lo_q  <= nib_lo_d;
      cont_q    <= cont_d;
      bad_q     <= bad_d;
      dout_q    <= dout_d;
    end
  end

  // Next-state logic: shift command/address/mode on SCK rise, drive data on SCK fall
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    mode_hi_d = mode_hi_q;
    nib_lo_d  = nib_lo_q;
    cont_d    = cont_q;
    bad_d     = 1'b0;
    dout_d    = dout_q;

    if ((state_q != S_IDLE) && ce_n_q) begin
      // Deselect ends any transaction; cont_mode keeps whatever it last held
      state_d  = S_IDLE;
      cnt_d    = 8'd0;
      cmd_d    = 7'd0;
      nib_lo_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_ce_fall) begin
            state_d  = cont_q ? S_ADDR : S_CMD;
            cnt_d    = 8'd0;
            cmd_d    = 7'd0;
            nib_lo_d = 1'b0;
          end
        end
        S_CMD: begin
          if (w_sck_rise) begin
            cmd_d = w_cmd_full[6:0];
            if (cnt_q == 8'd7) begin
              cnt_d = 8'd0;
              if (w_cmd_full == c_CMD_QIOR) begin
                state_d = S_ADDR;
              end else begin
                bad_d   = 1'b1;
                state_d = S_IGNORE;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_ADDR: begin
          if (w_sck_rise) begin
            addr_d = {addr_q[19:0], din_q};
            if (cnt_q == 8'd5) begin
              cnt_d   = 8'd0;
              state_d = S_MODE;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_MODE: begin
          if (w_sck_rise) begin
            if (cnt_q == 8'd0) begin
              mode_hi_d = din_q[1:0];
              cnt_d     = 8'd1;
            end else begin
              cont_d  = (mode_hi_q == 2'b10);
              cnt_d   = 8'd0;
              state_d = S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (w_sck_rise) begin
            if (cnt_q == c_LAST_DUMMY) begin
              cnt_d    = 8'd0;
              nib_lo_d = 1'b0;
              state_d  = S_DATA;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_DATA: begin
          if (w_sck_fall) begin
            if (nib_lo_q) begin
              dout_d = w_rd_byte[3:0];
              addr_d = addr_q + 24'd1;   // only the low ADDR_BITS index, so it wraps
            end else begin
              dout_d = w_rd_byte[7:4];
            end
            nib_lo_d = ~nib_lo_q;
          end
        end
        S_IGNORE: begin
          // wait for deselect
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign douten    = (state_q == S_DATA);
  assign cont_mode = cont_q;
  assign bad_cmd   = bad_q;

endmodule
`default_nettype wire

// File: doc/qspi_flash_resp.md
QSPI_FLASH_RESP -- requirements
Module: qspi_flash_resp

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, giving a byte-array size of 2^ADDR_BITS.
REQ-002 SHALL have parameter DUMMY_CYCLES, default 4, giving the number of SCK cycles between the mode byte and the first data nibble.
REQ-003 SHALL have one clock and one reset: synchronous, active-high.
REQ-004 SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sck  in  1  QSPI serial clock from the initiator
- ce_n  in  1  chip enable, active-low
- din  in  4  IO[3:0] driven by the initiator
- dout  out  4  IO[3:0] driven by this responder
- douten  out  1  high while the responder drives IO
- mem_we  in  1  preload write strobe
- mem_waddr  in  ADDR_BITS  preload byte address
- mem_wdata  in  8  preload byte
- cont_mode  out  1  continuous-read mode is armed
- bad_cmd  out  1  one-cycle pulse when an unsupported command is received

Function
REQ-005 SHALL respond only to the Quad I/O Fast Read command 0xEB. It is the flash end of the link whose initiator sends 0xEB, a 24-bit address, a mode byte and dummy cycles, then reads data.
REQ-006 SHALL register sck, ce_n and din once. The clk frequency SHALL be at least 4x the SCK frequency. SCK edges SHALL be detected by comparing the registered sck with its previous value.
REQ-007 SHALL sample din on each detected SCK rising edge while ce_n is low.
REQ-008 SHALL change dout only in the clk cycle after a detected SCK falling edge.
REQ-009 SHALL implement these states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
REQ-010 IDLE: ce_n falling SHALL go to CMD, or to ADDR when cont_mode=1.
REQ-011 CMD: SHALL shift in 8 bits from din[0], MSB first.
- Value 0xEB: go to ADDR.
- Any other value: pulse bad_cmd for one cycle and go to IGNORE.
REQ-012 ADDR: SHALL shift in 6 nibbles, most significant first, into a 24-bit address. Only bits [ADDR_BITS-1:0] index the array.
REQ-013 MODE: SHALL shift in 2 nibbles. After the second nibble, mode[5:4]==2'b10 SHALL set cont_mode; any other value SHALL clear it.
REQ-014 DUMMY: SHALL count DUMMY_CYCLES rising edges, then go to DATA.
REQ-015 DATA: SHALL present each byte high nibble first, then low nibble. The address SHALL increment after each low nibble, wrapping from 2^ADDR_BITS-1 to 0. Data SHALL continue until ce_n rises; there is no length limit.
REQ-016 The first data nibble SHALL be on dout after the falling edge that follows the last dummy rising edge.
REQ-017 douten SHALL be 1 only in DATA. It SHALL go to 0 within 2 clk cycles of ce_n rising.
REQ-018 IGNORE: SHALL hold douten=0 until ce_n rises.
REQ-019 ce_n rising in any state SHALL return to IDLE and clear the shift and bit counters. An aborted transaction (not in DATA) SHALL leave cont_mode unchanged.
REQ-020 sck edges while ce_n is high SHALL be ignored.
REQ-021 mem_we SHALL write mem_wdata at mem_waddr at the clk edge, in any state.
REQ-022 A simultaneous preload write and data read of the same byte SHALL return the old byte.
REQ-023 The array contents SHALL be unaffected by rst. The array is uninitialized until preloaded.

Reset
REQ-024 rst SHALL force the following, with reset priority over every other input:
- state = IDLE
- dout = 0
- douten = 0
- cont_mode = 0
- bad_cmd = 0
- all counters = 0
REQ-025 rst asserted mid-transaction SHALL abort it. The responder SHALL stay in IDLE until the next ce_n falling edge after rst is released.

Verification
REQ-026 Preload bytes 0x00..0x0F with 0x10..0x1F. Issue 0xEB, address 0x000000, mode 0x00, 4 dummy cycles, then 32 data nibbles. Expect nibbles 1,0,1,1,...,1,F; cont_mode=0.
REQ-027 Issue command 0x03. Expect a bad_cmd pulse, douten held 0 for the whole transaction, and state IDLE after ce_n rises.
REQ-028 Raise ce_n after 3 address nibbles, then issue a full read at 0x000004. Expect data starting at byte 0x14.
REQ-029 Read at address 0x0003FF with ADDR_BITS=10. Expect byte[0x3FF] followed by byte[0x000].
REQ-030 Read with mode 0xA0. Expect cont_mode=1. Then a transaction with no command byte at address 0x000008 SHALL return 0x18 first.
REQ-031 Assert rst during DATA. Expect douten=0 and cont_mode=0 on the next clk.
